// File: rtl/bcd_display_scan_pkg.sv
// Shared definitions for the BCD 7-segment scan display.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
// Output polarity is applied later, in the top block.
package bcd_display_scan_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic {
    EMPTY = 1'b0,
    SHOW  = 1'b1
  } state_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to 7-segment decoder (active-high, {g,f,e,d,c,b,a}).
// Nibbles above 9 decode to a dash so invalid digits remain visible.
module bcd_to_seg7
  import bcd_display_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Lookup of the segment pattern for one nibble
  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed 7-segment driver for the packed BCD converter result.
// Captures the frame once per bcd_done level, scans digits with a guard gap,
// blanks leading zeros and shows a dash for nibbles above 9.
// Optional feature macro: BCD_SIGN_EN adds the bcd_neg input and a sign dash.
module bcd_display_scan
  import bcd_display_scan_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,  // cycles per digit slot, at least 4
  parameter int GUARD_CYCLES = 2,      // dark cycles at slot start, below REFRESH_DIV
  parameter bit ACTIVE_LOW   = 1'b1
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        bcd_done,
  input  logic [15:0] bcd_in,
`ifdef BCD_SIGN_EN
  input  logic        bcd_neg,
`endif
  input  logic        clear,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        loaded
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD     = PW'(GUARD_CYCLES);

  // Inactive levels of the pins in the selected polarity
  localparam logic [6:0] SEG_IDLE = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_IDLE  = ACTIVE_LOW ? 4'hF  : 4'h0;
  localparam logic       DP_IDLE  = ACTIVE_LOW;

  state_e          state_q,  state_d;
  logic [15:0]     frame_q,  frame_d;
  logic [PW-1:0]   presc_q,  presc_d;
  logic [1:0]      digit_q,  digit_d;
  logic            done_q,   done_d;
  logic            loaded_q, loaded_d;
  logic [6:0]      seg_q,    seg_d;
  logic [3:0]      an_q,     an_d;
`ifdef BCD_SIGN_EN
  logic            neg_q,    neg_d;
  logic [1:0]      msd;
`endif

  logic            capture;
  logic [3:0]      nib [NUM_DIGITS];
  logic [3:0]      nz;
  logic [3:0]      blank;
  logic            zero_above;
  logic [3:0]      nib_sel;
  logic [6:0]      dec_seg;
  logic [6:0]      pat;
  logic            anode_on;
  logic [6:0]      seg_act;
  logic [3:0]      an_act;

  // Edge detect on bcd_done and the EMPTY/SHOW transitions; clear has priority
  always_comb begin
    capture  = bcd_done & ~done_q;
    done_d   = bcd_done;
    state_d  = state_q;
    frame_d  = frame_q;
    loaded_d = 1'b0;
`ifdef BCD_SIGN_EN
    neg_d    = neg_q;
`endif
    if (clear) begin
      state_d = EMPTY;
    end else if (capture) begin
      state_d  = SHOW;
      frame_d  = bcd_in;
      loaded_d = 1'b1;
`ifdef BCD_SIGN_EN
      neg_d    = bcd_neg;
`endif
    end
  end

  // Prescaler and digit index run continuously, in both states
  always_comb begin
    presc_d = presc_q + PW'(1);
    digit_d = digit_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      digit_d = digit_q + 2'd1;
    end
  end

  // Split the frame into nibbles and mark leading zeros (digit 0 never blanks)
  always_comb begin
    blank      = 4'b0000;
    zero_above = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nib[k] = frame_q[4*k +: 4];
      nz[k]  = (nib[k] != 4'd0);
    end
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & ~nz[k];
      blank[k]   = zero_above;
    end
  end

  assign nib_sel = nib[digit_d];

  bcd_to_seg7 u_dec (
    .nibble (nib_sel),
    .seg    (dec_seg)
  );

  // Pattern for the digit that becomes active after this edge, then polarity
  always_comb begin
    pat = blank[digit_d] ? SEG_BLANK : dec_seg;
`ifdef BCD_SIGN_EN
    msd = 2'd0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (nz[k]) msd = 2'(k);
    end
    if (neg_q) begin
      if (nz[3]) begin
        pat = SEG_DASH;
      end else if ({1'b0, digit_d} == ({1'b0, msd} + 3'd1)) begin
        pat = SEG_DASH;
      end
    end
`endif
    anode_on = (state_q == SHOW) && (presc_d >= GUARD);
    an_act   = anode_on ? (4'b0001 << digit_d) : 4'b0000;
    seg_act  = anode_on ? pat : SEG_BLANK;
    seg_d    = ACTIVE_LOW ? ~seg_act : seg_act;
    an_d     = ACTIVE_LOW ? ~an_act  : an_act;
  end

  // Control, frame and scan registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= EMPTY;
      frame_q  <= 16'h0000;
      presc_q  <= '0;
      digit_q  <= 2'd0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
`ifdef BCD_SIGN_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      presc_q  <= presc_d;
      digit_q  <= digit_d;
      done_q   <= done_d;
      loaded_q <= loaded_d;
`ifdef BCD_SIGN_EN
      neg_q    <= neg_d;
`endif
    end
  end

  // Registered pin drivers, forced inactive during reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_IDLE;
      an_q  <= AN_IDLE;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg    = seg_q;
  assign an     = an_q;
  assign dp     = DP_IDLE;
  assign loaded = loaded_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan with REFRESH_DIV=4, GUARD_CYCLES=1, ACTIVE_LOW=1.
module tb_bcd_display_scan;

  localparam int RD = 4;
  localparam int GC = 1;

  logic        clk;
  logic        reset;
  logic        bcd_done;
  logic [15:0] bcd_in;
  logic        clear;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        loaded;

  int checks = 0;
  int errors = 0;

  bcd_display_scan #(
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (GC),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bcd_done (bcd_done),
    .bcd_in   (bcd_in),
    .clear    (clear),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .loaded   (loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Active-low glyph of one displayed position of a frame
  function automatic logic [6:0] glyph(input logic [15:0] frame, input int k);
    int v;
    int d;
    v = int'(frame) >> (4 * k);
    if (k > 0 && v == 0) return 7'h7F;
    d = v % 16;
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Reference model: n edges since reset give slot position n%RD, digit (n/RD)%4
  int          n;
  bit          m_show;
  logic [15:0] m_frame;
  bit          m_prev;
  bit          cap;
  int          p;
  int          d;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_loaded;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n = 0; m_show = 0; m_frame = 16'h0; m_prev = 0;
      e_seg = 7'h7F; e_an = 4'hF; e_loaded = 1'b0;
    end else begin
      n++;
      p = n % RD;
      d = (n / RD) % 4;
      if (m_show && p >= GC) begin
        e_an  = ~(4'b0001 << d);
        e_seg = glyph(m_frame, d);
      end else begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
      end
      cap      = bcd_done && !m_prev;
      e_loaded = cap && !clear;
      if (clear) m_show = 0;
      else if (cap) begin m_show = 1; m_frame = bcd_in; end
      m_prev = bcd_done;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("seg", seg, e_seg);
    chk("an", an, e_an);
    chk("loaded", loaded, e_loaded);
    chk("dp", dp, 1);
  end

  task automatic wait_an(input logic [3:0] target, input logic [6:0] seg_exp, input string name);
    int k;
    bit found;
    found = 0;
    k = 0;
    while (!found && k < 40) begin
      @(negedge clk);
      if (an === target) found = 1;
      k++;
    end
    if (!found) chk({name, "_timeout"}, 0, 1);
    else chk(name, seg, seg_exp);
  endtask

  task automatic pulse_capture(input logic [15:0] val);
    bcd_in   = val;
    bcd_done = 1'b1;
    repeat (2) @(negedge clk);
    bcd_done = 1'b0;
  endtask

  initial begin
    int cnt;
    int dark_bad;
    reset = 1'b1; bcd_done = 1'b0; bcd_in = 16'h0; clear = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_an", an, 4'hF);
    reset = 1'b1;

    // Idle in EMPTY
    dark_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (an !== 4'hF || seg !== 7'h7F || loaded !== 1'b0) dark_bad++;
    end
    chk("idle_dark", dark_bad, 0);

    // Long bcd_done level gives a single capture
    bcd_in = 16'h0107; bcd_done = 1'b1;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (loaded === 1'b1) cnt++; end
    bcd_done = 1'b0;
    repeat (2) begin @(negedge clk); if (loaded === 1'b1) cnt++; end
    chk("loaded_count", cnt, 1);
    wait_an(4'b1110, 7'h78, "f0107_d0");
    wait_an(4'b1101, 7'h40, "f0107_d1");
    wait_an(4'b1011, 7'h79, "f0107_d2");
    wait_an(4'b0111, 7'h7F, "f0107_d3");

    // All-zero frame shows a single 0
    pulse_capture(16'h0000);
    wait_an(4'b1110, 7'h40, "f0000_d0");
    wait_an(4'b1101, 7'h7F, "f0000_d1");
    wait_an(4'b1011, 7'h7F, "f0000_d2");
    wait_an(4'b0111, 7'h7F, "f0000_d3");

    // Invalid nibble shows a dash
    pulse_capture(16'h00A3);
    wait_an(4'b1110, 7'h30, "f00a3_d0");
    wait_an(4'b1101, 7'h3F, "f00a3_d1");
    wait_an(4'b1011, 7'h7F, "f00a3_d2");
    wait_an(4'b0111, 7'h7F, "f00a3_d3");

    // clear together with the rising edge of bcd_done
    bcd_in = 16'h1234; bcd_done = 1'b1; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_no_loaded", loaded, 0);
    cnt = 0; dark_bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (loaded === 1'b1) cnt++;
      if (an !== 4'hF) dark_bad++;
    end
    chk("clear_late_loaded", cnt, 0);
    chk("clear_dark", dark_bad, 0);
    bcd_done = 1'b0;
    @(negedge clk);

    // Asynchronous reset while digit 2 is active
    pulse_capture(16'h1234);
    wait_an(4'b1011, 7'h24, "f1234_d2");
    #2 reset = 1'b0;
    #1;
    chk("async_seg", seg, 7'h7F);
    chk("async_an", an, 4'hF);
    chk("async_loaded", loaded, 0);
    @(negedge clk);
    reset = 1'b1;
    dark_bad = 0;
    repeat (6) begin @(negedge clk); if (an !== 4'hF) dark_bad++; end
    chk("post_reset_dark", dark_bad, 0);
    pulse_capture(16'h0005);
    wait_an(4'b1110, 7'h12, "f0005_d0");
    wait_an(4'b1101, 7'h7F, "f0005_d1");

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Downstream consumer of the binary-to-BCD converter in the calculator datapath.
- Captures the 16-bit packed BCD result (4 digits) when the converter signals completion and holds it in a local frame register.
- Time-multiplexes the four digits onto a common-cathode/anode 7-segment display, with leading-zero blanking and an invalid-digit indication.
- Only block that drives the board's segment and anode pins.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit slot is active (min 4).
- GUARD_CYCLES, 2, cycles at the start of each slot with all anodes inactive, for anti-ghosting (must be < REFRESH_DIV).
- ACTIVE_LOW, 1, 1 means seg/an/dp are driven active-low; 0 means active-high.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- bcd_done  in  1  converter completion level; held high until the converter returns to idle
- bcd_in  in  16  packed BCD: [15:12] thousands … [3:0] units; sampled only on capture
- clear  in  1  synchronous blank request, single-cycle pulse
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point, always inactive
- an  out  4  digit enables; an[0] is units
- loaded  out  1  one-cycle pulse, the cycle after a capture

Behaviour:
- Reset (reset low, asynchronous):
  - State is EMPTY; frame register = 0; prescaler = 0; digit index = 0; done_q = 0.
  - seg, an and dp all inactive: 7'h7F / 4'hF / 1 when ACTIVE_LOW=1. loaded = 0.
- Capture:
  - capture = bcd_done & ~done_q, where done_q is bcd_done registered.
  - Exactly one capture per high level of bcd_done, regardless of how long it is held.
  - On capture: frame <= bcd_in, state <= SHOW, loaded = 1 in the next cycle.
- State machine, two states:
  - EMPTY: anodes inactive, prescaler and scan still run. EMPTY -> SHOW on capture.
  - SHOW: anodes scan. SHOW -> EMPTY on clear. SHOW -> SHOW on capture (new frame replaces old).
  - clear and capture in the same cycle: clear wins, state = EMPTY, frame unchanged, no loaded pulse. done_q still updates, so that level is consumed.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index increments 0->1->2->3->0.
  - Active anode = one-hot(digit index) while prescaler >= GUARD_CYCLES; all anodes inactive otherwise.
- Digit decode:
  - 0-9 use the standard map. Active-low examples: 0 = 7'h40, 1 = 7'h79, 7 = 7'h78, 8 = 7'h00.
  - Nibble > 9 shows a dash: only g lit, 7'h3F.
- Leading-zero blanking:
  - Digit k (k = 3..1) is blank (all segments off, anode still asserted) if it and every higher digit are 0.
  - Digit 0 is never blanked, so value 0000 shows a single "0".
  - A nibble > 9 counts as non-zero for blanking purposes.
- Timing: seg and an are registered. A frame captured at edge E is visible on the active digit at edge E+1.
- ACTIVE_LOW=0 inverts seg, an and dp relative to the above.

Optional Feature:
- Macro: BCD_SIGN_EN.
- Defined:
  - Adds input port bcd_neg (1 bit), latched with the frame on capture.
  - When the latched sign is 1, the digit position immediately left of the most significant displayed digit shows a dash.
  - If thousands is non-zero and negative, all four digits show dashes (overflow).
- Undefined: no bcd_neg port; all values display unsigned.

Decomposition:
- Shared package: segment pattern constants (SEG_BLANK, SEG_DASH, 0-9 map), the state encoding (EMPTY, SHOW), and the digit count constant 4.
- One natural sub-module: bcd_to_seg7, a combinational nibble-to-segment decoder with the dash for >9. It is reusable by other display paths.
- Prescaler, scan, capture and FSM stay in the top block.

Test Plan (REFRESH_DIV=4, GUARD_CYCLES=1, ACTIVE_LOW=1):
- Reset then idle 20 cycles -> an = 4'hF throughout, seg = 7'h7F, loaded = 0.
- bcd_done high 10 cycles with bcd_in = 16'h0107 -> exactly one loaded pulse. Over the scan: an[0] slot seg = 7'h78, an[1] slot seg = 7'h40, an[2] slot seg = 7'h79, an[3] slot blank 7'h7F. Guard cycle in each slot has an = 4'hF.
- Capture 16'h0000 -> only digit 0 shows 7'h40; the other three slots are blank.
- Capture 16'h00A3 -> digit 1 shows 7'h3F, digit 0 shows the "3" pattern, digits 3/2 blank.
- clear asserted in the same cycle as the rising edge of bcd_done -> state EMPTY, an = 4'hF, no loaded pulse. Holding bcd_done high afterwards causes no late capture.
- reset asserted mid-scan with digit index = 2 -> outputs go inactive asynchronously. After release, scan restarts at digit 0 in EMPTY.
